// File: rtl/sample_rate_ctrl.sv
// Sample-rate controller: owns the divider prescaler, commits it at a divided-clock
// boundary and turns divider rising edges into burst capture strobes.
// Optional: define SRC_WATCHDOG_EN to force-commit in APPLY after a stalled divider.
module sample_rate_ctrl #(
    parameter int                 PRE_W     = 6,
    parameter int                 CNT_W     = 16,
    parameter logic [PRE_W-1:0]   PRE_RESET = PRE_W'(10)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PRE_W-1:0] cfg_pre,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             start,
    input  logic             stop,
    input  logic             div_clk,
    output logic [PRE_W-1:0] pre,
    output logic             sample_stb,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_ARM   = 2'd2,
        ST_RUN   = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PRE_W-1:0] PRE_MIN = PRE_W'(1);

    state_e           state_q, state_d;
    logic             div_q;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PRE_W-1:0] pre_pend_q, pre_pend_d;
    logic [CNT_W-1:0] count_cfg_q, count_cfg_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             sample_stb_q, sample_stb_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             div_edge_s;
    logic             cfg_accept_s;
    logic             start_accept_s;
    logic             commit_s;
    logic             abort_s;
    logic             strobe_s;
    logic             last_s;
    logic             wd_expire_s;

    assign div_edge_s     = div_clk & ~div_q;
    // cfg wins over a simultaneous start; a zero-length burst is never armed
    assign cfg_accept_s   = (state_q == ST_IDLE) & cfg_valid;
    assign start_accept_s = (state_q == ST_IDLE) & ~cfg_valid & start & (count_cfg_q != '0);
    assign commit_s       = (state_q == ST_APPLY) & (div_edge_s | stop | wd_expire_s);
    assign abort_s        = ((state_q == ST_ARM) | (state_q == ST_RUN)) & stop;
    assign strobe_s       = (state_q == ST_RUN) & div_edge_s & ~stop;
    assign last_s         = strobe_s & (remaining_q == CNT_ONE);

`ifdef SRC_WATCHDOG_EN
    localparam int WD_W = PRE_W + 2;

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

    assign wd_expire_s = (state_q == ST_APPLY) & ~div_edge_s & (wd_cnt_q == '1);

    // Stall timer: cleared outside APPLY so every APPLY visit starts from zero
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q != ST_APPLY) begin
            wd_cnt_d = '0;
        end else if (div_edge_s) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    // Stall timer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end
`else
    assign wd_expire_s = 1'b0;
`endif

    // State register and divider-level history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_clk;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_accept_s) begin
                    state_d = ST_APPLY;
                end else if (start_accept_s) begin
                    state_d = ST_ARM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_APPLY: begin
                if (commit_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_APPLY;
                end
            end
            ST_ARM: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (div_edge_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_ARM;
                end
            end
            ST_RUN: begin
                if (stop || last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and output next values
    always_comb begin
        pre_d        = pre_q;
        pre_pend_d   = pre_pend_q;
        count_cfg_d  = count_cfg_q;
        remaining_d  = remaining_q;

        if (cfg_accept_s) begin
            pre_pend_d  = (cfg_pre == '0) ? PRE_MIN : cfg_pre;
            count_cfg_d = cfg_count;
        end else begin
            pre_pend_d  = pre_pend_q;
            count_cfg_d = count_cfg_q;
        end

        if (commit_s) begin
            pre_d = pre_pend_q;
        end else begin
            pre_d = pre_q;
        end

        if (start_accept_s) begin
            remaining_d = count_cfg_q;
        end else if (abort_s) begin
            remaining_d = '0;
        end else if (strobe_s) begin
            remaining_d = remaining_q - CNT_ONE;
        end else begin
            remaining_d = remaining_q;
        end

        // Registered flags derive from the next state so they line up with it
        sample_stb_d = strobe_s;
        done_d       = last_s;
        cfg_ready_d  = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q        <= PRE_RESET;
            pre_pend_q   <= PRE_RESET;
            count_cfg_q  <= '0;
            remaining_q  <= '0;
            cfg_ready_q  <= 1'b1;
            sample_stb_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            pre_q        <= pre_d;
            pre_pend_q   <= pre_pend_d;
            count_cfg_q  <= count_cfg_d;
            remaining_q  <= remaining_d;
            cfg_ready_q  <= cfg_ready_d;
            sample_stb_q <= sample_stb_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
        end
    end

    assign pre        = pre_q;
    assign cfg_ready  = cfg_ready_q;
    assign sample_stb = sample_stb_q;
    assign done       = done_q;
    assign busy       = busy_q;

endmodule
